window_fetch_ctrl: RTL and testbench
====================================

# window_fetch_ctrl

Frame-walking controller that feeds the 3x3 window buffer ahead of the Sobel core. It reads pixels from image memory in a serpentine window order, delivers each pixel to the window buffer over the start_read/read_done handshake, and issues shift commands over the start_shift/shift_done handshake between windows. It presents each completed window to the downstream Sobel stage and waits for acknowledgement before moving on.

## Interface
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in pixels (≥3)
- ADDR_W, 16, memory address width (must hold IMG_W*IMG_H-1)
- BASE_ADDR, 0, address of pixel (0,0); pixel (x,y) at BASE_ADDR + y*IMG_W + x
- clk  in  1  clock; one clock domain, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- mem_re  out  1  one-cycle memory read request
- mem_addr  out  ADDR_W  read address, valid with mem_re
- mem_rdata  in  8  read data
- mem_rvalid  in  1  mem_rdata valid; any latency ≥1 cycle after mem_re
- start_read  out  1  pixel delivery request to window buffer
- start_shift  out  1  shift request to window buffer
- shift_direc  out  2  00 full load, 01 shift left (window moves right), 10 shift right (window moves left), 11 shift down
- data_r  out  8  pixel to window buffer, registered
- read_done  in  1  window buffer accepted pixel
- shift_done  in  1  window buffer completed shift
- win_valid  out  1  window complete, level until win_ack
- win_x, win_y  out  8 each  image coordinates of window centre
- win_ack  in  1  Sobel stage consumed window
- busy  out  1  high from start accepted to frame_done
- frame_done  out  1  one-cycle pulse after last window acked

## Operation
- States: IDLE, SHIFT, REQ, WAIT_DATA, PUSH, WIN_OUT, DONE.
- Window top-left (wx,wy); wx in 0..IMG_W-3, wy in 0..IMG_H-3. Direction flag dir_r: 1 = moving right.
- Frame order: row wy=0 left to right, step down, row wy=1 right to left, alternating (serpentine).
- First window: shift_direc=00, no shift; 9 reads row-major: rows wy..wy+2, cols wx..wx+2 within each row.
- Move right: SHIFT with 01, then 3 reads col wx+3, rows wy, wy+1, wy+2.
- Move left: SHIFT with 10, then 3 reads col wx-1, rows wy..wy+2 top to bottom.
- Move down (at row end): SHIFT with 11, then 3 reads row wy+3, cols wx..wx+2 left to right; dir_r toggles.
- Per pixel: REQ (mem_re=1, mem_addr) -> WAIT_DATA until mem_rvalid, latch mem_rdata into data_r -> PUSH.
- PUSH: start_read held high until read_done sampled high; deasserted next cycle; pixel counter increments.
- SHIFT: start_shift held high until shift_done sampled high; deasserted next cycle.
- shift_direc is held constant from SHIFT entry through the last PUSH of that window.
- After last pixel of a window: WIN_OUT, win_valid=1, win_x=wx+1, win_y=wy+1, held until win_ack; then next move or DONE.
- DONE: frame_done=1 one cycle, busy=0, return to IDLE.
- Totals per frame: windows (IMG_W-2)*(IMG_H-2); reads 9 + 3*(windows-1).

## Timing
- Reset: every output 0 (shift_direc=00, data_r=0, mem_addr=0); state IDLE; counters, wx, wy cleared; dir_r=1.
- Reset mid-frame: same as above in the next cycle; partial window discarded; no frame_done.
- start accepted in IDLE: REQ entered next cycle, busy high same edge.
- start during busy: ignored.
- start_read and start_shift never high together; at least one low cycle between any two requests.
- Minimum per-pixel cost with 1-cycle memory and combinational done: 4 cycles (REQ, WAIT_DATA, PUSH, release).
- mem_rvalid outside WAIT_DATA: ignored. win_ack outside WIN_OUT: ignored.
- read_done/shift_done high in the same cycle as the request counts as completion.
- IMG_W=3: no horizontal moves; only downs. IMG_H=3: single row; no downs. IMG_W=IMG_H=3: one full load, one window, DONE.

## Test plan
- IMG_W=IMG_H=5, mem[a]=a, 1-cycle memory, win_ack immediate -> reads 0,1,2,5,6,7,10,11,12 | 01:3,8,13 | 01:4,9,14 | 11:17,18,19 | 10:6,11,16 | 10:5,10,15 | 11:20,21,22 | 01:13,18,23 | 01:14,19,24; 33 reads, one frame_done.
- Same frame -> 9 win_valid with centres (1,1),(2,1),(3,1),(3,2),(2,2),(1,2),(1,3),(2,3),(3,3).
- Random memory latency 1-6 cycles, read_done/shift_done delayed 0-3 cycles -> identical address/direction sequence; start_read/start_shift never overlap; shift_direc stable per window.
- win_ack withheld 20 cycles on window 4 -> win_valid held, no mem_re, no start_* during stall.
- rst asserted mid-read of window 5 -> all outputs 0 next cycle; new start reproduces full sequence from address 0.
- IMG_W=IMG_H=3 -> 9 reads 0..8 with shift_direc=00, no start_shift, one window at (1,1), frame_done.

Source files
------------

// File: rtl/window_fetch_ctrl.sv
// Serpentine 3x3 window walker: fetches pixels from image memory, pushes them to
// the window buffer, issues shifts between windows and hands each window to Sobel.
//
// state     | meaning
// IDLE      | waiting for start
// SHIFT     | start_shift held until shift_done, then one release cycle
// REQ       | one-cycle memory read request
// WAIT_DATA | waiting for mem_rvalid, latch pixel
// PUSH      | start_read held until read_done, then one release cycle
// WIN_OUT   | window presented, waiting for win_ack
// DONE      | frame_done pulse
module window_fetch_ctrl #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic              o_start_read,
  output logic              o_start_shift,
  output logic [1:0]        o_shift_direc,
  output logic [7:0]        o_data_r,
  input  logic              i_read_done,
  input  logic              i_shift_done,
  output logic              o_win_valid,
  output logic [7:0]        o_win_x,
  output logic [7:0]        o_win_y,
  input  logic              i_win_ack,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT     = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_PUSH      = 3'd4;
  localparam logic [2:0] S_WIN_OUT   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [1:0] DIR_FULL  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [2:0] r_state;
  logic [7:0] r_wx, r_wy;
  logic       r_dir;
  logic [1:0] r_pr, r_pc;
  logic [3:0] r_cnt;
  logic       r_start_read, r_start_shift;
  logic [1:0] r_shift_direc;
  logic [7:0] r_data;

  logic [7:0]        w_x_off, w_y_off, w_px, w_py;
  logic [ADDR_W-1:0] w_addr;
  logic              w_load_done, w_row_end, w_last_row;

  // wx/wy already point at the new window while its fresh pixels are fetched
  always_comb begin
    w_x_off = {6'd0, r_pc};
    w_y_off = {6'd0, r_pr};
    if (r_shift_direc == DIR_RIGHT) w_x_off = 8'd2;
    else if (r_shift_direc == DIR_LEFT) w_x_off = 8'd0;
    if (r_shift_direc == DIR_DOWN) w_y_off = 8'd2;
  end

  assign w_px        = r_wx + w_x_off;
  assign w_py        = r_wy + w_y_off;
  assign w_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(w_py) * ADDR_W'(IMG_W) + ADDR_W'(w_px);
  assign w_load_done = (r_shift_direc == DIR_FULL) ? (r_cnt == 4'd9) : (r_cnt == 4'd3);
  assign w_row_end   = r_dir ? (r_wx == 8'(IMG_W - 3)) : (r_wx == 8'd0);
  assign w_last_row  = (r_wy == 8'(IMG_H - 3));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wx          <= 8'd0;
      r_wy          <= 8'd0;
      r_dir         <= 1'b1;
      r_pr          <= 2'd0;
      r_pc          <= 2'd0;
      r_cnt         <= 4'd0;
      r_start_read  <= 1'b0;
      r_start_shift <= 1'b0;
      r_shift_direc <= DIR_FULL;
      r_data        <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state       <= S_REQ;
            r_wx          <= 8'd0;
            r_wy          <= 8'd0;
            r_dir         <= 1'b1;
            r_pr          <= 2'd0;
            r_pc          <= 2'd0;
            r_cnt         <= 4'd0;
            r_shift_direc <= DIR_FULL;
          end
        end
        S_SHIFT: begin
          if (r_start_shift) begin
            if (i_shift_done) r_start_shift <= 1'b0;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_REQ: r_state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          if (i_mem_rvalid) begin
            r_data       <= i_mem_rdata;
            r_start_read <= 1'b1;
            r_state      <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (r_start_read) begin
            if (i_read_done) begin
              r_start_read <= 1'b0;
              r_cnt        <= r_cnt + 4'd1;
              case (r_shift_direc)
                DIR_FULL: begin
                  if (r_pc == 2'd2) begin
                    r_pc <= 2'd0;
                    r_pr <= r_pr + 2'd1;
                  end else begin
                    r_pc <= r_pc + 2'd1;
                  end
                end
                DIR_DOWN: r_pc <= r_pc + 2'd1;
                default:  r_pr <= r_pr + 2'd1;
              endcase
            end
          end else begin
            r_state <= w_load_done ? S_WIN_OUT : S_REQ;
          end
        end
        S_WIN_OUT: begin
          if (i_win_ack) begin
            r_cnt <= 4'd0;
            r_pr  <= 2'd0;
            r_pc  <= 2'd0;
            if (w_row_end && w_last_row) begin
              r_state <= S_DONE;
            end else begin
              r_state       <= S_SHIFT;
              r_start_shift <= 1'b1;
              if (w_row_end) begin
                r_wy          <= r_wy + 8'd1;
                r_dir         <= ~r_dir;
                r_shift_direc <= DIR_DOWN;
              end else if (r_dir) begin
                r_wx          <= r_wx + 8'd1;
                r_shift_direc <= DIR_RIGHT;
              end else begin
                r_wx          <= r_wx - 8'd1;
                r_shift_direc <= DIR_LEFT;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_re      = (r_state == S_REQ);
  assign o_mem_addr    = o_mem_re ? w_addr : '0;
  assign o_start_read  = r_start_read;
  assign o_start_shift = r_start_shift;
  assign o_shift_direc = r_shift_direc;
  assign o_data_r      = r_data;
  assign o_win_valid   = (r_state == S_WIN_OUT);
  assign o_win_x       = o_win_valid ? r_wx + 8'd1 : 8'd0;
  assign o_win_y       = o_win_valid ? r_wy + 8'd1 : 8'd0;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_frame_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: 5x5 frames with randomized memory/handshake timing,
// an ack stall, a mid-frame reset, plus a 3x3 frame on a second instance.
module tb_window_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 5x5 instance
  logic        i_rst, i_start, i_mem_rvalid, i_read_done, i_shift_done, i_win_ack;
  logic [7:0]  i_mem_rdata;
  logic        o_mem_re, o_start_read, o_start_shift, o_win_valid, o_busy, o_frame_done;
  logic [15:0] o_mem_addr;
  logic [1:0]  o_shift_direc;
  logic [7:0]  o_data_r, o_win_x, o_win_y;

  window_fetch_ctrl #(.IMG_W(5), .IMG_H(5), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
    .o_start_read(o_start_read), .o_start_shift(o_start_shift),
    .o_shift_direc(o_shift_direc), .o_data_r(o_data_r),
    .i_read_done(i_read_done), .i_shift_done(i_shift_done),
    .o_win_valid(o_win_valid), .o_win_x(o_win_x), .o_win_y(o_win_y),
    .i_win_ack(i_win_ack), .o_busy(o_busy), .o_frame_done(o_frame_done));

  // 3x3 instance
  logic        s3_start, s3_rvalid, s3_read_done, s3_shift_done, s3_ack;
  logic [7:0]  s3_rdata;
  logic        s3_mem_re, s3_start_read, s3_start_shift, s3_win_valid, s3_busy, s3_frame_done;
  logic [15:0] s3_mem_addr;
  logic [1:0]  s3_shift_direc;
  logic [7:0]  s3_data_r, s3_win_x, s3_win_y;

  window_fetch_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(16), .BASE_ADDR(0)) dut_3x3 (
    .i_clk(clk), .i_rst(i_rst), .i_start(s3_start),
    .o_mem_re(s3_mem_re), .o_mem_addr(s3_mem_addr),
    .i_mem_rdata(s3_rdata), .i_mem_rvalid(s3_rvalid),
    .o_start_read(s3_start_read), .o_start_shift(s3_start_shift),
    .o_shift_direc(s3_shift_direc), .o_data_r(s3_data_r),
    .i_read_done(s3_read_done), .i_shift_done(s3_shift_done),
    .o_win_valid(s3_win_valid), .o_win_x(s3_win_x), .o_win_y(s3_win_y),
    .i_win_ack(s3_ack), .o_busy(s3_busy), .o_frame_done(s3_frame_done));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference: serpentine window list, expected read addresses, directions, centres
  int exp_addr[$];
  int exp_dir[$];
  int exp_cx[$];
  int exp_cy[$];

  function automatic void build_ref(input int w, input int h);
    int px[$];
    int py[$];
    exp_addr.delete(); exp_dir.delete(); exp_cx.delete(); exp_cy.delete();
    for (int y = 0; y <= h - 3; y++)
      for (int i = 0; i <= w - 3; i++) begin
        py.push_back(y);
        px.push_back((y % 2 == 0) ? i : (w - 3 - i));
      end
    for (int k = 0; k < px.size(); k++) begin
      exp_cx.push_back(px[k] + 1);
      exp_cy.push_back(py[k] + 1);
      if (k == 0) begin
        exp_dir.push_back(0);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) exp_addr.push_back((py[k] + r) * w + px[k] + c);
      end else if (py[k] != py[k-1]) begin
        exp_dir.push_back(3);
        for (int c = 0; c < 3; c++) exp_addr.push_back((py[k] + 2) * w + px[k] + c);
      end else if (px[k] > px[k-1]) begin
        exp_dir.push_back(1);
        for (int r = 0; r < 3; r++) exp_addr.push_back((py[k] + r) * w + px[k] + 2);
      end else begin
        exp_dir.push_back(2);
        for (int r = 0; r < 3; r++) exp_addr.push_back((py[k] + r) * w + px[k]);
      end
    end
  endfunction

  // monitor / responder state for the 5x5 instance
  int ridx, pidx, widx, n_frame, n_viol, stall_cycles;
  int lat_max, dly_max, ack_max, stall_win, noise;
  int m_cnt, rd_w, sh_w, ack_w;
  logic [7:0] m_addr;
  logic prev_sr, prev_ss, prev_wv;

  task automatic mon();
    if (o_mem_re) begin
      if (ridx < exp_addr.size()) chk("addr", o_mem_addr, exp_addr[ridx]);
      else chk("extra_read", ridx, exp_addr.size());
      ridx++;
    end
    if (o_start_read && !prev_sr) begin
      if (pidx < exp_addr.size()) chk("data", o_data_r, exp_addr[pidx] & 255);
      if (widx < exp_dir.size()) chk("dir_at_read", o_shift_direc, exp_dir[widx]);
      pidx++;
    end
    if (o_start_shift && !prev_ss && widx < exp_dir.size())
      chk("dir_at_shift", o_shift_direc, exp_dir[widx]);
    if (o_start_read && o_start_shift) n_viol++;
    if ((o_start_read && !prev_sr && prev_ss) || (o_start_shift && !prev_ss && prev_sr)) n_viol++;
    if (o_win_valid && (o_mem_re || o_start_read || o_start_shift)) n_viol++;
    if (o_win_valid && !prev_wv) begin
      if (widx < exp_cx.size()) begin
        chk("win_x", o_win_x, exp_cx[widx]);
        chk("win_y", o_win_y, exp_cy[widx]);
      end else chk("extra_win", widx, exp_cx.size());
      widx++;
    end
    if (o_frame_done) begin
      n_frame++;
      chk("busy_at_done", o_busy, 0);
    end
    prev_sr = o_start_read;
    prev_ss = o_start_shift;
    prev_wv = o_win_valid;
  endtask

  task automatic resp();
    i_mem_rvalid = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = m_addr;
      end
    end
    if (o_mem_re) begin
      m_cnt  = $urandom_range(lat_max, 1);
      m_addr = o_mem_addr[7:0];
    end
    if (o_start_read) begin
      if (rd_w < 0) rd_w = $urandom_range(dly_max, 0);
      i_read_done = (rd_w == 0);
      if (rd_w > 0) rd_w--;
    end else begin
      rd_w = -1;
      i_read_done = (noise != 0) && ($urandom_range(3, 0) == 0);
    end
    if (o_start_shift) begin
      if (sh_w < 0) sh_w = $urandom_range(dly_max, 0);
      i_shift_done = (sh_w == 0);
      if (sh_w > 0) sh_w--;
    end else begin
      sh_w = -1;
      i_shift_done = (noise != 0) && ($urandom_range(3, 0) == 0);
    end
    if (o_win_valid) begin
      if (widx - 1 == stall_win) stall_cycles++;
      if (ack_w < 0) ack_w = (widx - 1 == stall_win) ? 20 : $urandom_range(ack_max, 0);
      i_win_ack = (ack_w == 0);
      if (ack_w > 0) ack_w--;
    end else begin
      ack_w = -1;
      i_win_ack = (noise != 0) && ($urandom_range(3, 0) == 0);
    end
  endtask

  // 3x3 instance: 1-cycle memory, same-cycle dones, immediate ack
  int s3_addr[$];
  int s3_data[$];
  int s3_nshift, s3_baddir, s3_nwin, s3_cx, s3_cy, s3_nframe;
  logic s3_pend, s3_prev_sr, s3_prev_wv;
  logic [7:0] s3_paddr;

  task automatic mon3();
    s3_rvalid = s3_pend;
    s3_rdata  = s3_paddr;
    s3_pend   = 1'b0;
    if (s3_mem_re) begin
      s3_addr.push_back(s3_mem_addr);
      s3_pend  = 1'b1;
      s3_paddr = s3_mem_addr[7:0];
    end
    if (s3_start_read && !s3_prev_sr) begin
      s3_data.push_back(s3_data_r);
      if (s3_shift_direc != 2'b00) s3_baddir++;
    end
    if (s3_start_shift) s3_nshift++;
    if (s3_win_valid && !s3_prev_wv) begin
      s3_nwin++;
      s3_cx = s3_win_x;
      s3_cy = s3_win_y;
    end
    if (s3_frame_done) s3_nframe++;
    s3_read_done  = s3_start_read;
    s3_shift_done = s3_start_shift;
    s3_ack        = s3_win_valid;
    s3_prev_sr    = s3_start_read;
    s3_prev_wv    = s3_win_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    resp();
    mon3();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {o_mem_re, o_start_read, o_start_shift, o_win_valid, o_busy, o_frame_done}, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_dir"}, o_shift_direc, 0);
    chk({tag, "_data"}, o_data_r, 0);
    chk({tag, "_win"}, {o_win_x, o_win_y}, 0);
  endtask

  task automatic run_frame(input int lat, input int dly, input int ack, input int stall,
                           input int nz, input int abort_at);
    bit fin = 1'b0;
    lat_max = lat; dly_max = dly; ack_max = ack; stall_win = stall; noise = nz;
    ridx = 0; pidx = 0; widx = 0; n_frame = 0; n_viol = 0; stall_cycles = 0;
    m_cnt = 0; rd_w = -1; sh_w = -1; ack_w = -1;
    i_start = 1'b1;
    tick();
    chk("busy_after_start", o_busy, 1);
    chk("first_req", o_mem_re, 1);
    i_start = 1'b0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      tick();
      if (n_frame > 0) begin
        fin = 1'b1;
      end else if (abort_at > 0 && ridx == abort_at) begin
        i_rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        i_rst = 1'b0;
        i_start = 1'b0;
        tick();
        chk("no_done_after_rst", n_frame, 0);
        chk("idle_after_rst", o_busy, 0);
        fin = 1'b1;
      end else begin
        i_start = (nz != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
    i_start = 1'b0;
    if (!fin) chk("frame_timeout", 0, 1);
    if (abort_at == 0) begin
      chk("n_reads", ridx, exp_addr.size());
      chk("n_push", pidx, exp_addr.size());
      chk("n_win", widx, exp_cx.size());
      chk("n_frame_done", n_frame, 1);
    end
    chk("handshake_rules", n_viol, 0);
    repeat (3) tick();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 8'd0;
    i_read_done = 1'b0; i_shift_done = 1'b0; i_win_ack = 1'b0;
    s3_start = 1'b0; s3_rvalid = 1'b0; s3_rdata = 8'd0;
    s3_read_done = 1'b0; s3_shift_done = 1'b0; s3_ack = 1'b0;
    s3_pend = 1'b0; s3_paddr = 8'd0; s3_prev_sr = 1'b0; s3_prev_wv = 1'b0;
    s3_nshift = 0; s3_baddir = 0; s3_nwin = 0; s3_cx = 0; s3_cy = 0; s3_nframe = 0;
    prev_sr = 1'b0; prev_ss = 1'b0; prev_wv = 1'b0;
    lat_max = 1; dly_max = 0; ack_max = 0; stall_win = -1; noise = 0;
    m_cnt = 0; rd_w = -1; sh_w = -1; ack_w = -1; m_addr = 8'd0;
    ridx = 0; pidx = 0; widx = 0; n_frame = 0; n_viol = 0; stall_cycles = 0;

    build_ref(5, 5);
    repeat (3) tick();
    chk_reset_outputs("reset");
    i_rst = 1'b0;
    repeat (2) tick();

    run_frame(1, 0, 0, -1, 0, 0);            // fixed 1-cycle memory, immediate handshakes
    run_frame(6, 3, 2, 3, 1, 0);             // random timing, ack stall on window 4
    chk("stall_win_valid_cycles", stall_cycles, 21);
    run_frame(6, 3, 2, -1, 1, 19);           // reset once window 5 starts reading
    run_frame(6, 3, 2, -1, 1, 0);            // full frame again from address 0
    run_frame(1, 0, 0, -1, 0, 0);

    build_ref(3, 3);
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    for (int c = 0; c < 500 && s3_nframe == 0; c++) tick();
    repeat (3) tick();
    chk("s3_n_reads", s3_addr.size(), 9);
    for (int k = 0; k < 9 && k < s3_addr.size(); k++) chk("s3_addr", s3_addr[k], exp_addr[k]);
    for (int k = 0; k < 9 && k < s3_data.size(); k++) chk("s3_data", s3_data[k], exp_addr[k]);
    chk("s3_bad_dir", s3_baddir, 0);
    chk("s3_shifts", s3_nshift, 0);
    chk("s3_n_win", s3_nwin, 1);
    chk("s3_centre", {s3_cx[7:0], s3_cy[7:0]}, {8'd1, 8'd1});
    chk("s3_frame_done", s3_nframe, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
